// File: rtl/sndbus_if.sv
// sndbus_if: AY-slot snoop signals and local YM chip bus of sndbus_seq
interface sndbus_if #(parameter int NUM_CHIPS = 2);
    logic                 aybdir, aybc1, aybc2, aya8, aya9_n;
    logic [7:0]           ayd_in, ayd_out, d_in, d_out;
    logic                 ayd_oe, d_oe, wr_n, rd_n, a0;
    logic [NUM_CHIPS-1:0] cs_n;
    logic [1:0]           cfg_sel;
    logic                 cfg_stat, cfg_dac, busy, ovf;
    modport slave (
        input  aybdir, aybc1, aybc2, aya8, aya9_n, ayd_in, d_in,
        output ayd_out, ayd_oe, d_out, d_oe, cs_n, wr_n, rd_n, a0,
               cfg_sel, cfg_stat, cfg_dac, busy, ovf
    );
    modport master (
        output aybdir, aybc1, aybc2, aya8, aya9_n, ayd_in, d_in,
        input  ayd_out, ayd_oe, d_out, d_oe, cs_n, wr_n, rd_n, a0,
               cfg_sel, cfg_stat, cfg_dac, busy, ovf
    );
endinterface

// File: rtl/sndbus_seq.sv
// sndbus_seq: AY-slot bus snooper driving local YM chips through a timed strobe sequencer
module sndbus_seq #(
    parameter int NUM_CHIPS = 2,
    parameter int SETUP_CYC = 3,
    parameter int PULSE_CYC = 8,
    parameter int HOLD_CYC  = 2,
    parameter int RECOV_CYC = 16
) (
    input logic     clk,
    input logic     rst_n,
    sndbus_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RECOV} state_t;
    typedef struct packed {
        logic       rd;
        logic [1:0] chip;
        logic       a0;
        logic [7:0] data;
        logic       tok;
    } req_t;

    localparam logic [7:0] SL = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PL = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HL = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RL = 8'(RECOV_CYC - 1);
    localparam logic [2:0] NC = 3'(NUM_CHIPS);

    // {bdir, bc1, bc2, a8, a9_n}: two synchroniser stages plus one history stage for the stability check
    logic [4:0] s1_q, s2_q, p_q;
    logic       armed_q, armed_d;
    logic [1:0] cfg_sel_q;
    logic       cfg_stat_q, cfg_dac_q, ovf_q, ovf_d;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, lim;
    req_t       cur_q, cur_d, buf_q, buf_d, nreq;
    logic       buf_v_q, buf_v_d;
    logic [7:0] ayd_out_q;
    logic       rd_own_q, rd_own_d, rd_cap_q, rd_cap_d, tok_q;
    logic [1:0] cyc;
    logic       stable, valid, acc, is_cfg, nreq_v, sel_ok, done, act, cap_now;

    assign cyc     = s2_q[4:3];
    assign stable  = s2_q == p_q;
    assign valid   = s2_q[2] & s2_q[1] & ~s2_q[0];
    assign acc     = armed_q & stable & valid & (cyc != 2'b00);
    assign is_cfg  = (cyc == 2'b11) && (bus.ayd_in[7:4] == 4'hF);
    assign nreq_v  = acc & ~is_cfg;
    assign sel_ok  = {1'b0, ~bus.ayd_in[1:0]} < NC;
    assign nreq    = '{rd: cyc == 2'b01, chip: cfg_sel_q,
                       a0: (cyc == 2'b01) ? ~cfg_stat_q : (cyc == 2'b10),
                       data: bus.ayd_in, tok: ~tok_q};
    assign lim     = state_q == SETUP ? SL : state_q == PULSE ? PL : state_q == HOLD ? HL : RL;
    assign done    = cnt_q == lim;
    assign act     = state_q == SETUP || state_q == PULSE || state_q == HOLD;
    assign cap_now = state_q == PULSE && done && cur_q.rd;

    // Re-arm only after the bus has been seen stably inactive, so each cycle is accepted once
    assign armed_d  = acc ? 1'b0 : (stable && cyc == 2'b00) ? 1'b1 : armed_q;
    // Read data goes to the Speccy only for the read belonging to the still-active bus read cycle
    assign rd_own_d = (cyc == 2'b01) & (acc | rd_own_q);
    assign rd_cap_d = rd_own_q & (cyc == 2'b01) & ~acc & (rd_cap_q | (cap_now & cur_q.tok == tok_q));

    // Sequencer next state, request routing into the pending buffer and overflow detection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        cur_d   = cur_q;
        buf_d   = buf_q;
        buf_v_d = buf_v_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (buf_v_q) begin
                    state_d = SETUP;
                    cur_d   = buf_q;
                    buf_v_d = nreq_v;
                    buf_d   = nreq_v ? nreq : buf_q;
                end else if (nreq_v) begin
                    state_d = SETUP;
                    cur_d   = nreq;
                end
            end
            SETUP: if (done) begin state_d = PULSE; cnt_d = '0; end
            PULSE: if (done) begin state_d = HOLD; cnt_d = '0; end
            HOLD:  if (done) begin state_d = (RECOV_CYC == 0) ? IDLE : RECOV; cnt_d = '0; end
            RECOV: if (done) begin state_d = IDLE; cnt_d = '0; end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && nreq_v) begin
            if (!buf_v_q) begin
                buf_v_d = 1'b1;
                buf_d   = nreq;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // All state registers, including synchroniser, config register and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            p_q        <= '0;
            armed_q    <= 1'b0;
            cfg_sel_q  <= '0;
            cfg_stat_q <= 1'b0;
            cfg_dac_q  <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            buf_q      <= '0;
            buf_v_q    <= 1'b0;
            ayd_out_q  <= '0;
            rd_own_q   <= 1'b0;
            rd_cap_q   <= 1'b0;
            tok_q      <= 1'b0;
        end else begin
            s1_q     <= {bus.aybdir, bus.aybc1, bus.aybc2, bus.aya8, bus.aya9_n};
            s2_q     <= s1_q;
            p_q      <= s2_q;
            armed_q  <= armed_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            buf_q    <= buf_d;
            buf_v_q  <= buf_v_d;
            rd_own_q <= rd_own_d;
            rd_cap_q <= rd_cap_d;
            if (acc && cyc == 2'b01) tok_q <= ~tok_q;
            if (cap_now) ayd_out_q <= bus.d_in;
            if (acc && is_cfg) begin
                cfg_stat_q <= ~bus.ayd_in[2];
                cfg_dac_q  <= ~bus.ayd_in[3];
                if (sel_ok) cfg_sel_q <= ~bus.ayd_in[1:0];
            end
        end
    end

    for (genvar i = 0; i < NUM_CHIPS; i++) begin : g_cs
        assign bus.cs_n[i] = ~(act && cur_q.chip == 2'(i));
    end

    assign bus.d_oe     = act & ~cur_q.rd;
    assign bus.d_out    = (act & ~cur_q.rd) ? cur_q.data : 8'h00;
    assign bus.wr_n     = ~(state_q == PULSE && !cur_q.rd);
    assign bus.rd_n     = ~(state_q == PULSE && cur_q.rd);
    assign bus.a0       = act & cur_q.a0;
    assign bus.ayd_out  = ayd_out_q;
    assign bus.ayd_oe   = rd_own_q & rd_cap_q;
    assign bus.cfg_sel  = cfg_sel_q;
    assign bus.cfg_stat = cfg_stat_q;
    assign bus.cfg_dac  = cfg_dac_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_sndbus_seq.sv
// tb_sndbus_seq: directed stimulus with a scoreboard of expected local accesses
module tb_sndbus_seq;
    localparam int CS_LEN = 13;
    localparam int STR    = 8;
    localparam int GAP    = 17;

    typedef struct {
        int         chip;
        bit         rd;
        bit         a0;
        logic [7:0] d;
        int         gap;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, rst1_n = 1'b0;
    int   checks = 0, errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    sndbus_if #(.NUM_CHIPS(2)) b0();
    sndbus_if #(.NUM_CHIPS(1)) b1();

    sndbus_seq #(.NUM_CHIPS(2)) dut  (.clk(clk), .rst_n(rst_n),  .bus(b0.slave));
    sndbus_seq #(.NUM_CHIPS(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1.slave));

    assign b1.aybdir = b0.aybdir;
    assign b1.aybc1  = b0.aybc1;
    assign b1.aybc2  = b0.aybc2;
    assign b1.aya8   = b0.aya8;
    assign b1.aya9_n = b0.aya9_n;
    assign b1.ayd_in = b0.ayd_in;
    assign b1.d_in   = b0.d_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bus_cyc(input logic bdir, input logic bc1, input logic [7:0] d, input int hold, input int idle);
        @(negedge clk);
        b0.aybdir = bdir;
        b0.aybc1  = bc1;
        b0.ayd_in = d;
        repeat (hold) @(negedge clk);
        b0.aybdir = 1'b0;
        b0.aybc1  = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 300) begin
            @(negedge clk);
            quiet = b0.busy ? 0 : quiet + 1;
            n++;
        end
        chk("wait_idle", quiet >= 3, 1);
    endtask

    int         cs_cnt, wr_cnt, rd_cnt, gap_at;
    int         gap = 9999;
    bit         in_acc = 1'b0;
    logic [1:0] csv;
    logic       a0_s, doe_s;
    logic [7:0] dout_s;
    exp_t       e;

    // Monitor: measures each local access on the 2-chip DUT and checks it against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            in_acc = 1'b0;
        end else if (b0.cs_n != 2'b11) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                cs_cnt = 0;
                wr_cnt = 0;
                rd_cnt = 0;
                csv    = b0.cs_n;
                gap_at = gap;
            end
            cs_cnt++;
            if (!b0.wr_n) begin wr_cnt++; dout_s = b0.d_out; end
            if (!b0.rd_n) rd_cnt++;
            if (!b0.wr_n || !b0.rd_n) begin a0_s = b0.a0; doe_s = b0.d_oe; end
        end else if (in_acc) begin
            in_acc = 1'b0;
            gap = 1;
            chk("sb_pending", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("acc_cs", csv, e.chip == 1 ? 2'b01 : 2'b10);
                chk("acc_cs_len", cs_cnt, CS_LEN);
                chk("acc_strobe_len", e.rd ? rd_cnt : wr_cnt, STR);
                chk("acc_other_strobe", e.rd ? wr_cnt : rd_cnt, 0);
                chk("acc_a0", a0_s, e.a0);
                chk("acc_d_oe", doe_s, !e.rd);
                if (!e.rd) chk("acc_d_out", dout_s, e.d);
                if (e.gap >= 0) chk("acc_gap", gap_at, e.gap);
            end
        end else begin
            gap++;
        end
    end

    initial begin
        bit seen;
        int n;
        b0.aybdir = 1'b0;
        b0.aybc1  = 1'b0;
        b0.aybc2  = 1'b1;
        b0.aya8   = 1'b1;
        b0.aya9_n = 1'b0;
        b0.ayd_in = 8'h00;
        b0.d_in   = 8'hC3;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", b0.cs_n, 2'b11);
        chk("rst_wr_n", b0.wr_n, 1);
        chk("rst_rd_n", b0.rd_n, 1);
        chk("rst_a0", b0.a0, 0);
        chk("rst_d_oe", b0.d_oe, 0);
        chk("rst_d_out", b0.d_out, 8'h00);
        chk("rst_ayd_oe", b0.ayd_oe, 0);
        chk("rst_ayd_out", b0.ayd_out, 8'h00);
        chk("rst_cfg_sel", b0.cfg_sel, 0);
        chk("rst_cfg_stat", b0.cfg_stat, 0);
        chk("rst_cfg_dac", b0.cfg_dac, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_ovf", b0.ovf, 0);
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        repeat (4) @(negedge clk);

        bus_cyc(1, 1, 8'hFE, 6, 4);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen |= b0.busy; end
        chk("cfg_sel_fe", b0.cfg_sel, 1);
        chk("cfg_stat_fe", b0.cfg_stat, 0);
        chk("cfg_dac_fe", b0.cfg_dac, 0);
        chk("cfg_no_busy", seen, 0);
        chk("cfg1_sel_kept", b1.cfg_sel, 0);

        q.push_back('{chip: 1, rd: 0, a0: 0, d: 8'h07, gap: -1});
        q.push_back('{chip: 1, rd: 0, a0: 1, d: 8'h5A, gap: GAP});
        bus_cyc(1, 1, 8'h07, 6, 4);
        bus_cyc(1, 0, 8'h5A, 6, 4);
        wait_idle();

        bus_cyc(1, 1, 8'hFA, 6, 4);
        chk("cfg_sel_fa", b0.cfg_sel, 1);
        chk("cfg_stat_fa", b0.cfg_stat, 1);
        chk("cfg_dac_fa", b0.cfg_dac, 0);
        q.push_back('{chip: 1, rd: 1, a0: 0, d: 8'h00, gap: -1});
        @(negedge clk);
        b0.aybdir = 1'b0;
        b0.aybc1  = 1'b1;
        repeat (6) @(negedge clk);
        chk("rd_oe_before_cap", b0.ayd_oe, 0);
        repeat (20) @(negedge clk);
        chk("rd_oe_after_cap", b0.ayd_oe, 1);
        chk("rd_ayd_out", b0.ayd_out, 8'hC3);
        b0.aybc1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("rd_oe_released", b0.ayd_oe, 0);
        wait_idle();

        chk("ovf_before", b0.ovf, 0);
        q.push_back('{chip: 1, rd: 0, a0: 1, d: 8'h11, gap: -1});
        q.push_back('{chip: 1, rd: 0, a0: 1, d: 8'h22, gap: GAP});
        bus_cyc(1, 0, 8'h11, 3, 3);
        bus_cyc(1, 0, 8'h22, 3, 3);
        bus_cyc(1, 0, 8'h33, 3, 3);
        wait_idle();
        chk("ovf_after", b0.ovf, 1);

        @(negedge clk);
        b0.aybdir = 1'b1;
        @(negedge clk);
        b0.aybdir = 1'b0;
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= b0.busy; end
        chk("glitch_no_busy", seen, 0);

        q.push_back('{chip: 1, rd: 0, a0: 1, d: 8'h66, gap: -1});
        @(negedge clk);
        b0.aybdir = 1'b1;
        b0.ayd_in = 8'h66;
        repeat (3) @(negedge clk);
        b0.aybdir = 1'b0;
        n = 0;
        while (b1.wr_n && n < 50) begin @(negedge clk); n++; end
        chk("rst_pulse_found", b1.wr_n, 0);
        rst1_n = 1'b0;
        #1;
        chk("rst_pulse_wr_n", b1.wr_n, 1);
        chk("rst_pulse_cs_n", b1.cs_n, 1);
        chk("rst_pulse_busy", b1.busy, 0);
        chk("rst_pulse_d_oe", b1.d_oe, 0);
        chk("rst_pulse_ovf", b1.ovf, 0);
        wait_idle();
        repeat (5) @(negedge clk);
        rst1_n = 1'b1;
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
